// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_pkg
//  Description : Shared constants for the 8-bit pipelined core: ALU opcodes,
//                branch types, CCR flag bit indices and forwarding selects.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    // ALU opcodes
    localparam logic [3:0] C_OP_NOP    = 4'd0;
    localparam logic [3:0] C_OP_MOV    = 4'd1;
    localparam logic [3:0] C_OP_ADD    = 4'd2;
    localparam logic [3:0] C_OP_SUB    = 4'd3;
    localparam logic [3:0] C_OP_AND    = 4'd4;
    localparam logic [3:0] C_OP_OR     = 4'd5;
    localparam logic [3:0] C_OP_RLC    = 4'd6;
    localparam logic [3:0] C_OP_RRC    = 4'd7;
    localparam logic [3:0] C_OP_SETC   = 4'd8;
    localparam logic [3:0] C_OP_CLRC   = 4'd9;
    localparam logic [3:0] C_OP_NOT    = 4'd10;
    localparam logic [3:0] C_OP_NEG    = 4'd11;
    localparam logic [3:0] C_OP_INC    = 4'd12;
    localparam logic [3:0] C_OP_DEC    = 4'd13;
    localparam logic [3:0] C_OP_PASS_A = 4'd14;
    localparam logic [3:0] C_OP_RSV    = 4'd15;

    // Branch types
    localparam logic [2:0] C_BT_NONE = 3'd0;
    localparam logic [2:0] C_BT_JZ   = 3'd1;
    localparam logic [2:0] C_BT_JN   = 3'd2;
    localparam logic [2:0] C_BT_JC   = 3'd3;
    localparam logic [2:0] C_BT_JV   = 3'd4;
    localparam logic [2:0] C_BT_JMP  = 3'd5;
    localparam logic [2:0] C_BT_CALL = 3'd6;
    localparam logic [2:0] C_BT_RET  = 3'd7;

    // CCR bit positions, order {V,C,N,Z}
    localparam int Z_BIT = 0;
    localparam int N_BIT = 1;
    localparam int C_BIT = 2;
    localparam int V_BIT = 3;

    // Flag masks per op class
    localparam logic [3:0] C_MASK_NONE = 4'b0000;
    localparam logic [3:0] C_MASK_C    = 4'b0100;
    localparam logic [3:0] C_MASK_ZN   = 4'b0011;
    localparam logic [3:0] C_MASK_ZNC  = 4'b0111;
    localparam logic [3:0] C_MASK_ZNCV = 4'b1111;

    // Forwarding selects
    localparam logic [1:0] C_FWD_IDEX     = 2'd0;
    localparam logic [1:0] C_FWD_EXMEM    = 2'd1;
    localparam logic [1:0] C_FWD_MEMWB    = 2'd2;
    localparam logic [1:0] C_FWD_IDEX_ALT = 2'd3;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Combinational ALU. Produces the result, the candidate flag
//                values and the mask of flags the opcode is allowed to touch.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
    import core_pkg::*;
#(
    parameter int DW = 8,
    parameter int FW = 4
) (
    input  logic [DW-1:0] i_a,
    input  logic [DW-1:0] i_b,
    input  logic [3:0]    i_op,
    input  logic          i_c,
    output logic [DW-1:0] o_result,
    output logic [FW-1:0] o_flags,
    output logic [FW-1:0] o_mask
);

    localparam logic [DW:0] C_ONE  = {{DW{1'b0}}, 1'b1};
    localparam logic [DW:0] C_ZERO = '0;

    logic [DW:0] w_sum;
    logic        w_c;
    logic        w_v;

    // Opcode decode: result, carry/overflow candidates and touched-flag mask
    always_comb begin
        w_sum    = '0;
        o_result = i_b;
        w_c      = 1'b0;
        w_v      = 1'b0;
        o_mask   = C_MASK_NONE;
        case (i_op)
            C_OP_ADD: begin
                w_sum    = {1'b0, i_a} + {1'b0, i_b};
                o_result = w_sum[DW-1:0];
                w_c      = w_sum[DW];
                w_v      = (i_a[DW-1] == i_b[DW-1]) && (o_result[DW-1] != i_a[DW-1]);
                o_mask   = C_MASK_ZNCV;
            end
            C_OP_SUB: begin
                // Top bit of the widened difference is the borrow
                w_sum    = {1'b0, i_a} - {1'b0, i_b};
                o_result = w_sum[DW-1:0];
                w_c      = w_sum[DW];
                w_v      = (i_a[DW-1] != i_b[DW-1]) && (o_result[DW-1] != i_a[DW-1]);
                o_mask   = C_MASK_ZNCV;
            end
            C_OP_AND: begin
                o_result = i_a & i_b;
                o_mask   = C_MASK_ZN;
            end
            C_OP_OR: begin
                o_result = i_a | i_b;
                o_mask   = C_MASK_ZN;
            end
            C_OP_RLC: begin
                o_result = {i_b[DW-2:0], i_c};
                w_c      = i_b[DW-1];
                o_mask   = C_MASK_ZNC;
            end
            C_OP_RRC: begin
                o_result = {i_c, i_b[DW-1:1]};
                w_c      = i_b[0];
                o_mask   = C_MASK_ZNC;
            end
            C_OP_SETC: begin
                w_c    = 1'b1;
                o_mask = C_MASK_C;
            end
            C_OP_CLRC: begin
                w_c    = 1'b0;
                o_mask = C_MASK_C;
            end
            C_OP_NOT: begin
                o_result = ~i_b;
                o_mask   = C_MASK_ZN;
            end
            C_OP_NEG: begin
                w_sum    = C_ZERO - {1'b0, i_b};
                o_result = w_sum[DW-1:0];
                w_c      = w_sum[DW];
                w_v      = i_b[DW-1] && o_result[DW-1];
                o_mask   = C_MASK_ZNCV;
            end
            C_OP_INC: begin
                w_sum    = {1'b0, i_b} + C_ONE;
                o_result = w_sum[DW-1:0];
                w_c      = w_sum[DW];
                w_v      = !i_b[DW-1] && o_result[DW-1];
                o_mask   = C_MASK_ZNCV;
            end
            C_OP_DEC: begin
                // Carry reports borrow, matching SUB
                w_sum    = {1'b0, i_b} - C_ONE;
                o_result = w_sum[DW-1:0];
                w_c      = w_sum[DW];
                w_v      = i_b[DW-1] && !o_result[DW-1];
                o_mask   = C_MASK_ZNCV;
            end
            C_OP_PASS_A: o_result = i_a;
            default:     o_result = i_b;   // NOP, MOV, reserved
        endcase
    end

    // Pack candidate flags in CCR bit order
    always_comb begin
        o_flags        = '0;
        o_flags[Z_BIT] = (o_result == '0);
        o_flags[N_BIT] = o_result[DW-1];
        o_flags[C_BIT] = w_c;
        o_flags[V_BIT] = w_v;
    end

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ex_stage
//  Description : Execute stage. Operand forwarding, ALU, condition-code
//                register with interrupt shadow, and jump resolution.
//  Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
    import core_pkg::*;
#(
    parameter int DW = 8,
    parameter int FW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [3:0]    alu_op_i,
    input  logic          alu_src_i,
    input  logic          update_flags_i,
    input  logic [2:0]    btype_i,
    input  logic [DW-1:0] ra_val_i,
    input  logic [DW-1:0] rb_val_i,
    input  logic [DW-1:0] imm_i,
    input  logic [1:0]    fwd_a_sel_i,
    input  logic [1:0]    fwd_b_sel_i,
    input  logic [DW-1:0] exmem_fwd_i,
    input  logic [DW-1:0] memwb_fwd_i,
    input  logic          stall_i,
    input  logic          int_save_i,
    input  logic          rti_restore_i,
    output logic [DW-1:0] alu_result_o,
    output logic [DW-1:0] store_data_o,
    output logic [FW-1:0] flags_o,
    output logic          branch_taken_o,
    output logic [DW-1:0] branch_target_o
);

    logic [FW-1:0] r_ccr;
    logic [FW-1:0] r_shadow;

    logic [DW-1:0] w_fwd_a;
    logic [DW-1:0] w_fwd_b;
    logic [DW-1:0] w_op_b;
    logic [FW-1:0] w_alu_flags;
    logic [FW-1:0] w_alu_mask;
    logic [FW-1:0] w_ccr_upd;
    logic [FW-1:0] w_jmp_clr;
    logic [FW-1:0] w_ccr_next;
    logic          w_taken;

    // Forwarding muxes for both register operands
    always_comb begin
        case (fwd_a_sel_i)
            C_FWD_EXMEM: w_fwd_a = exmem_fwd_i;
            C_FWD_MEMWB: w_fwd_a = memwb_fwd_i;
            default:     w_fwd_a = ra_val_i;
        endcase
        case (fwd_b_sel_i)
            C_FWD_EXMEM: w_fwd_b = exmem_fwd_i;
            C_FWD_MEMWB: w_fwd_b = memwb_fwd_i;
            default:     w_fwd_b = rb_val_i;
        endcase
    end

    assign w_op_b          = alu_src_i ? imm_i : w_fwd_b;
    assign store_data_o    = w_fwd_b;
    assign branch_target_o = w_fwd_b;

    alu #(
        .DW (DW),
        .FW (FW)
    ) u_alu (
        .i_a      (w_fwd_a),
        .i_b      (w_op_b),
        .i_op     (alu_op_i),
        .i_c      (r_ccr[C_BIT]),
        .o_result (alu_result_o),
        .o_flags  (w_alu_flags),
        .o_mask   (w_alu_mask)
    );

    // Jump resolution from the current CCR; a taken conditional jump
    // also marks its tested flag for clearing
    always_comb begin
        w_taken   = 1'b0;
        w_jmp_clr = '0;
        case (btype_i)
            C_BT_JZ: begin
                w_taken          = r_ccr[Z_BIT];
                w_jmp_clr[Z_BIT] = r_ccr[Z_BIT];
            end
            C_BT_JN: begin
                w_taken          = r_ccr[N_BIT];
                w_jmp_clr[N_BIT] = r_ccr[N_BIT];
            end
            C_BT_JC: begin
                w_taken          = r_ccr[C_BIT];
                w_jmp_clr[C_BIT] = r_ccr[C_BIT];
            end
            C_BT_JV: begin
                w_taken          = r_ccr[V_BIT];
                w_jmp_clr[V_BIT] = r_ccr[V_BIT];
            end
            C_BT_JMP, C_BT_CALL: w_taken = 1'b1;
            default:             w_taken = 1'b0;   // none, RET resolved in MEM
        endcase
    end

    assign branch_taken_o = w_taken && !rst;

    // Next CCR: merge masked ALU flags, then clear the flag a taken jump tested
    assign w_ccr_upd  = update_flags_i ? ((r_ccr & ~w_alu_mask) | (w_alu_flags & w_alu_mask))
                                       : r_ccr;
    assign w_ccr_next = w_ccr_upd & ~w_jmp_clr;

    // CCR register: restore beats stall, stall beats normal update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ccr <= '0;
        end else if (rti_restore_i) begin
            r_ccr <= r_shadow;
        end else if (!stall_i) begin
            r_ccr <= w_ccr_next;
        end
    end

    // Interrupt shadow captures the value the CCR is about to take
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shadow <= '0;
        end else if (int_save_i && !stall_i && !rti_restore_i) begin
            r_shadow <= w_ccr_next;
        end
    end

    assign flags_o = r_ccr;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ex_stage
//  Description : Self-checking bench for ex_stage: directed scenarios plus
//                randomized cycles against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] alu_op_i = '0;
    logic       alu_src_i = 1'b0;
    logic       update_flags_i = 1'b0;
    logic [2:0] btype_i = '0;
    logic [7:0] ra_val_i = '0, rb_val_i = '0, imm_i = '0;
    logic [1:0] fwd_a_sel_i = '0, fwd_b_sel_i = '0;
    logic [7:0] exmem_fwd_i = '0, memwb_fwd_i = '0;
    logic       stall_i = 1'b0, int_save_i = 1'b0, rti_restore_i = 1'b0;
    logic [7:0] alu_result_o, store_data_o, branch_target_o;
    logic [3:0] flags_o;
    logic       branch_taken_o;

    int total = 0;
    int bad   = 0;

    // Reference state, flags in {V,C,N,Z} order
    logic [3:0] m_ccr = '0;
    logic [3:0] m_sh  = '0;

    // Observed outputs captured during the last cycle (before its edge)
    logic [7:0] obs_res, obs_tgt;
    logic       obs_tk;

    ex_stage #(.DW(8), .FW(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_op_i        (alu_op_i),
        .alu_src_i       (alu_src_i),
        .update_flags_i  (update_flags_i),
        .btype_i         (btype_i),
        .ra_val_i        (ra_val_i),
        .rb_val_i        (rb_val_i),
        .imm_i           (imm_i),
        .fwd_a_sel_i     (fwd_a_sel_i),
        .fwd_b_sel_i     (fwd_b_sel_i),
        .exmem_fwd_i     (exmem_fwd_i),
        .memwb_fwd_i     (memwb_fwd_i),
        .stall_i         (stall_i),
        .int_save_i      (int_save_i),
        .rti_restore_i   (rti_restore_i),
        .alu_result_o    (alu_result_o),
        .store_data_o    (store_data_o),
        .flags_o         (flags_o),
        .branch_taken_o  (branch_taken_o),
        .branch_target_o (branch_target_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural ALU: integer arithmetic, signed range test for overflow
    function automatic void model_alu(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                      input logic [3:0] ccr, output logic [7:0] res,
                                      output logic [3:0] nccr);
        int  ua, ub, sa, sb, r, sr;
        logic z, n, c, v, zn;
        ua = a; ub = b; sa = $signed(a); sb = $signed(b);
        z = ccr[0]; n = ccr[1]; c = ccr[2]; v = ccr[3];
        zn = 1'b0; res = b; r = 0; sr = 0;
        case (op)
            4'd2:  begin r = ua + ub; sr = sa + sb; c = (r > 255); v = (sr > 127 || sr < -128); zn = 1'b1; res = r[7:0]; end
            4'd3:  begin r = ua - ub; sr = sa - sb; c = (ua < ub); v = (sr > 127 || sr < -128); zn = 1'b1; res = r[7:0]; end
            4'd4:  begin res = a & b; zn = 1'b1; end
            4'd5:  begin res = a | b; zn = 1'b1; end
            4'd6:  begin r = ub * 2 + (ccr[2] ? 1 : 0); res = r[7:0]; c = (ub >= 128); zn = 1'b1; end
            4'd7:  begin r = ub / 2 + (ccr[2] ? 128 : 0); res = r[7:0]; c = (ub % 2 == 1); zn = 1'b1; end
            4'd8:  c = 1'b1;
            4'd9:  c = 1'b0;
            4'd10: begin r = 255 - ub; res = r[7:0]; zn = 1'b1; end
            4'd11: begin r = 0 - ub; sr = 0 - sb; c = (ub != 0); v = (sr > 127); zn = 1'b1; res = r[7:0]; end
            4'd12: begin r = ub + 1; sr = sb + 1; c = (r > 255); v = (sr > 127); zn = 1'b1; res = r[7:0]; end
            4'd13: begin r = ub - 1; sr = sb - 1; c = (ub == 0); v = (sr < -128); zn = 1'b1; res = r[7:0]; end
            4'd14: res = a;
            default: res = b;
        endcase
        if (zn) begin
            z = (res == 8'h00);
            n = (res >= 8'h80);
        end
        nccr = {v, c, n, z};
    endfunction

    // One pipeline cycle: drive at negedge, check combinational outputs,
    // then check the CCR after the rising edge
    task automatic cyc(input logic [3:0] op, input logic src, input logic upd, input logic [2:0] bt,
                       input logic [7:0] ra, input logic [7:0] rb, input logic [7:0] imm,
                       input logic [1:0] fa, input logic [1:0] fb, input logic [7:0] ex,
                       input logic [7:0] mw, input logic st, input logic sv, input logic rs);
        logic [7:0] a, fbv, b, e_res;
        logic [3:0] alu_ccr, nxt;
        logic       tk;
        @(negedge clk);
        alu_op_i = op; alu_src_i = src; update_flags_i = upd; btype_i = bt;
        ra_val_i = ra; rb_val_i = rb; imm_i = imm; fwd_a_sel_i = fa; fwd_b_sel_i = fb;
        exmem_fwd_i = ex; memwb_fwd_i = mw; stall_i = st; int_save_i = sv; rti_restore_i = rs;
        a   = (fa == 2'd1) ? ex : (fa == 2'd2) ? mw : ra;
        fbv = (fb == 2'd1) ? ex : (fb == 2'd2) ? mw : rb;
        b   = src ? imm : fbv;
        model_alu(op, a, b, m_ccr, e_res, alu_ccr);
        nxt = upd ? alu_ccr : m_ccr;
        tk  = 1'b0;
        if (bt >= 3'd1 && bt <= 3'd4) begin
            tk = m_ccr[bt - 3'd1];
            if (tk) nxt[bt - 3'd1] = 1'b0;
        end else if (bt == 3'd5 || bt == 3'd6) begin
            tk = 1'b1;
        end
        #2;
        obs_res = alu_result_o; obs_tk = branch_taken_o; obs_tgt = branch_target_o;
        check("res",    alu_result_o,    e_res);
        check("store",  store_data_o,    fbv);
        check("taken",  branch_taken_o,  tk);
        check("target", branch_target_o, fbv);
        if (rs) begin
            m_ccr = m_sh;
        end else if (!st) begin
            if (sv) m_sh = nxt;
            m_ccr = nxt;
        end
        @(posedge clk);
        #1;
        check("flags", flags_o, m_ccr);
    endtask

    initial begin
        // Reset state, jump suppressed while in reset
        btype_i = 3'd5;
        #1;
        check("rst_flags", flags_o, 4'b0000);
        check("rst_taken", branch_taken_o, 1'b0);
        @(negedge clk);
        rst = 1'b0; btype_i = 3'd0;

        // ADD overflow into sign bit, then wrap to zero
        cyc(4'd2, 1'b0, 1'b1, 3'd0, 8'h7F, 8'h01, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("add7f_res", obs_res, 8'h80);
        check("add7f_flags", flags_o, 4'b1010);
        cyc(4'd2, 1'b0, 1'b1, 3'd0, 8'hFF, 8'h01, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("addff_res", obs_res, 8'h00);
        check("addff_flags", flags_o, 4'b0101);

        // JZ taken with target forwarded from EX/MEM, then not taken
        cyc(4'd0, 1'b0, 1'b0, 3'd1, 8'h00, 8'h99, '0, '0, 2'd1, 8'h3C, '0, 1'b0, 1'b0, 1'b0);
        check("jz_taken", obs_tk, 1'b1);
        check("jz_target", obs_tgt, 8'h3C);
        check("jz_clear", flags_o, 4'b0100);
        cyc(4'd0, 1'b0, 1'b0, 3'd1, 8'h00, 8'h99, '0, '0, 2'd1, 8'h3C, '0, 1'b0, 1'b0, 1'b0);
        check("jz_not", obs_tk, 1'b0);
        check("jz_hold", flags_o, 4'b0100);

        // Rotates through carry
        cyc(4'd9, 1'b0, 1'b1, 3'd0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        cyc(4'd6, 1'b1, 1'b1, 3'd0, '0, '0, 8'h81, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("rlc_res", obs_res, 8'h02);
        check("rlc_c", flags_o[2], 1'b1);
        cyc(4'd7, 1'b1, 1'b1, 3'd0, '0, '0, 8'h02, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("rrc_res", obs_res, 8'h81);
        check("rrc_c", flags_o[2], 1'b0);

        // Interrupt save, clobber, restore; stalled update holds
        cyc(4'd2, 1'b0, 1'b1, 3'd0, 8'hFF, 8'h01, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        cyc(4'd0, 1'b0, 1'b0, 3'd0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        cyc(4'd3, 1'b0, 1'b1, 3'd0, 8'h05, 8'h05, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b0);
        check("sub55_flags", flags_o, 4'b0001);
        cyc(4'd0, 1'b0, 1'b0, 3'd0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("rti_flags", flags_o, 4'b0101);
        cyc(4'd2, 1'b0, 1'b1, 3'd0, 8'h7F, 8'h01, '0, '0, '0, '0, '0, 1'b1, 1'b0, 1'b0);
        check("stall_hold", flags_o, 4'b0101);

        // Forwarding from both later stages
        cyc(4'd3, 1'b0, 1'b1, 3'd0, 8'hAA, 8'h77, '0, 2'd2, 2'd1, 8'h05, 8'h10, 1'b0, 1'b0, 1'b0);
        check("fwd_res", obs_res, 8'h0B);
        check("fwd_c", flags_o[2], 1'b0);

        // Asynchronous reset in the middle of a jump cycle
        cyc(4'd2, 1'b0, 1'b1, 3'd0, 8'h80, 8'h80, '0, '0, '0, '0, '0, 1'b0, 1'b1, 1'b0);
        check("pre_rst_flags", flags_o, 4'b1101);
        @(negedge clk);
        alu_op_i = 4'd0; update_flags_i = 1'b0; btype_i = 3'd5; int_save_i = 1'b0;
        #1;
        check("jmp_taken", branch_taken_o, 1'b1);
        rst = 1'b1;
        #1;
        check("async_flags", flags_o, 4'b0000);
        check("async_taken", branch_taken_o, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        m_ccr = '0; m_sh = '0;
        // Shadow was cleared by reset as well
        cyc(4'd0, 1'b0, 1'b0, 3'd0, '0, '0, '0, '0, '0, '0, '0, 1'b0, 1'b0, 1'b1);
        check("rst_shadow", flags_o, 4'b0000);

        // Randomized cycles against the reference model
        for (int i = 0; i < 400; i++) begin
            cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
                2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 6) == 0),
                1'($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
